// File: rtl/complex_dot_product_stream_pkg.sv
// Shared types and helpers for the streaming complex dot-product unit:
// FSM encoding, lane field offsets and accumulator width derivation.
package complex_dot_product_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Full-precision width: product, one combine bit, tree growth, beat count.
  function automatic int acc_width(input int dw, input int lanes, input int cnt_w);
    return 2*dw + 1 + $clog2(lanes) + cnt_w;
  endfunction

  // Lane 0 sits in the most significant 2*dw bits; real above imag.
  function automatic int lane_re_lsb(input int k, input int lanes, input int dw);
    return (lanes - 1 - k)*2*dw + dw;
  endfunction

  function automatic int lane_im_lsb(input int k, input int lanes, input int dw);
    return (lanes - 1 - k)*2*dw;
  endfunction

endpackage

// File: rtl/complex_lane_mac.sv
// One complex lane: registers the four partial products, then combines them
// into full-width real/imag terms, optionally conjugating operand b.
module complex_lane_mac
  import complex_dot_product_stream_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 conj,
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  output logic signed [2*DW:0] re,
  output logic signed [2*DW:0] im
);

  localparam int PW = 2*DW;

  logic signed [PW-1:0] rr_p0_q, rr_p0_d;
  logic signed [PW-1:0] ii_p0_q, ii_p0_d;
  logic signed [PW-1:0] ri_p0_q, ri_p0_d;
  logic signed [PW-1:0] ir_p0_q, ir_p0_d;

  function automatic logic signed [PW-1:0] sext_op(input logic signed [DW-1:0] v);
    return {{DW{v[DW-1]}}, v};
  endfunction

  function automatic logic signed [PW:0] sext_prod(input logic signed [PW-1:0] v);
    return {v[PW-1], v};
  endfunction

  always_comb begin
    rr_p0_d = sext_op(a_re) * sext_op(b_re);
    ii_p0_d = sext_op(a_im) * sext_op(b_im);
    ri_p0_d = sext_op(a_re) * sext_op(b_im);
    ir_p0_d = sext_op(a_im) * sext_op(b_re);
  end

  // ---- stage p0: partial products ----
  always_ff @(posedge clk) begin
    rr_p0_q <= rr_p0_d;
    ii_p0_q <= ii_p0_d;
    ri_p0_q <= ri_p0_d;
    ir_p0_q <= ir_p0_d;
  end

  always_comb begin
    if (conj) begin
      re = sext_prod(rr_p0_q) + sext_prod(ii_p0_q);
      im = sext_prod(ir_p0_q) - sext_prod(ri_p0_q);
    end else begin
      re = sext_prod(rr_p0_q) - sext_prod(ii_p0_q);
      im = sext_prod(ri_p0_q) + sext_prod(ir_p0_q);
    end
  end

endmodule

// File: rtl/complex_dot_product_stream.sv
// Streaming complex dot product: LANES lanes per beat, adder tree, and a
// full-precision accumulator; the result is held until acknowledged.
module complex_dot_product_stream
  import complex_dot_product_stream_pkg::*;
#(
  parameter  int LANES = 8,
  parameter  int DW    = 16,
  parameter  int CNT_W = 8,
  localparam int LOG2L = $clog2(LANES),
  localparam int ACC_W = acc_width(DW, LANES, CNT_W)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_chunks,
  input  logic                    conj_b,
  input  logic [LANES*2*DW-1:0]   first_row_input,
  input  logic [LANES*2*DW-1:0]   second_row_input,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] result_re,
  output logic signed [ACC_W-1:0] result_im,
  output logic                    finish,
  input  logic                    outsider_read_now,
  output logic                    busy
);

  localparam int PW    = 2*DW + 1;
  localparam int SUM_W = PW + LOG2L;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, num_q, num_d;
  logic                    conj_q, conj_d;
  logic                    vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
  logic signed [SUM_W-1:0] sum_re_p1_q, sum_re_p1_d, sum_im_p1_q, sum_im_p1_d;
  logic signed [ACC_W-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic signed [PW-1:0]    lane_re [LANES];
  logic signed [PW-1:0]    lane_im [LANES];
  logic                    in_fire, last_beat, launch;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    complex_lane_mac #(.DW(DW)) u_mac (
      .clk  (clk),
      .conj (conj_q),
      .a_re (first_row_input[lane_re_lsb(k, LANES, DW) +: DW]),
      .a_im (first_row_input[lane_im_lsb(k, LANES, DW) +: DW]),
      .b_re (second_row_input[lane_re_lsb(k, LANES, DW) +: DW]),
      .b_im (second_row_input[lane_im_lsb(k, LANES, DW) +: DW]),
      .re   (lane_re[k]),
      .im   (lane_im[k])
    );
  end

  assign in_fire   = in_valid & in_ready;
  assign last_beat = (cnt_q == num_q - CNT_W'(1));
  assign launch    = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (num_chunks == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (in_fire && last_beat) state_d = ST_DRAIN;
      ST_DRAIN: if (!vld_p0_q && !vld_p1_q) state_d = ST_DONE;
      ST_DONE:  if (outsider_read_now) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_RUN);
    finish   = (state_q == ST_DONE);
    busy     = (state_q != ST_IDLE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    num_d    = num_q;
    conj_d   = conj_q;
    vld_p0_d = in_fire;
    vld_p1_d = vld_p0_q;
    if (launch) begin
      cnt_d  = '0;
      num_d  = num_chunks;
      conj_d = conj_b;
    end else if (in_fire) begin
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    sum_re_p1_d = '0;
    sum_im_p1_d = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_re_p1_d = sum_re_p1_d + {{LOG2L{lane_re[k][PW-1]}}, lane_re[k]};
      sum_im_p1_d = sum_im_p1_d + {{LOG2L{lane_im[k][PW-1]}}, lane_im[k]};
    end
  end

  always_comb begin
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    if (launch) begin
      acc_re_d = '0;
      acc_im_d = '0;
    end else if (vld_p1_q) begin
      acc_re_d = acc_re_q + {{(ACC_W-SUM_W){sum_re_p1_q[SUM_W-1]}}, sum_re_p1_q};
      acc_im_d = acc_im_q + {{(ACC_W-SUM_W){sum_im_p1_q[SUM_W-1]}}, sum_im_p1_q};
    end
  end

  // ---- stage p1: lane combine and adder tree ----
  always_ff @(posedge clk) begin
    sum_re_p1_q <= sum_re_p1_d;
    sum_im_p1_q <= sum_im_p1_d;
  end

  // ---- control, valid pipeline and accumulator (p2) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      num_q    <= '0;
      conj_q   <= 1'b0;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      conj_q   <= conj_d;
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
    end
  end

  assign result_re = acc_re_q;
  assign result_im = acc_im_q;

endmodule

// File: tb/tb_complex_dot_product_stream.sv
// Directed bench for complex_dot_product_stream with hand-computed results.
module tb_complex_dot_product_stream;

  localparam int LANES = 8;
  localparam int DW    = 16;
  localparam int CNT_W = 8;
  localparam int ACC_W = 44;
  localparam int VW    = LANES*2*DW;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    start = 1'b0;
  logic [CNT_W-1:0]        num_chunks = '0;
  logic                    conj_b = 1'b0;
  logic [VW-1:0]           first_row_input = '0;
  logic [VW-1:0]           second_row_input = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [ACC_W-1:0] result_re;
  logic signed [ACC_W-1:0] result_im;
  logic                    finish;
  logic                    outsider_read_now = 1'b0;
  logic                    busy;

  int total  = 0;
  int passed = 0;

  complex_dot_product_stream dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .num_chunks        (num_chunks),
    .conj_b            (conj_b),
    .first_row_input   (first_row_input),
    .second_row_input  (second_row_input),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .result_re         (result_re),
    .result_im         (result_im),
    .finish            (finish),
    .outsider_read_now (outsider_read_now),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic set_uniform(input int ar, input int ai, input int br, input int bi);
    for (int k = 0; k < LANES; k++) begin
      first_row_input[(LANES-1-k)*2*DW +: 2*DW]  = {ar[15:0], ai[15:0]};
      second_row_input[(LANES-1-k)*2*DW +: 2*DW] = {br[15:0], bi[15:0]};
    end
  endtask

  task automatic set_ramp();
    for (int k = 0; k < LANES; k++) begin
      int v;
      v = k + 1;
      first_row_input[(LANES-1-k)*2*DW +: 2*DW]  = {v[15:0], 16'h0000};
      second_row_input[(LANES-1-k)*2*DW +: 2*DW] = {v[15:0], 16'h0000};
    end
  endtask

  task automatic do_start(input int n, input bit c);
    start = 1'b1; num_chunks = n[7:0]; conj_b = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Holds in_valid until n beats are taken; returns at the negedge after the last one.
  task automatic feed(input int n);
    int got = 0;
    int guard = 0;
    in_valid = 1'b1;
    while (got < n && guard < 1000) begin
      if (in_ready) got++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_finish(output int k, output bit timed_out);
    k = 0;
    while (finish !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    timed_out = (finish !== 1'b1);
  endtask

  task automatic ack();
    outsider_read_now = 1'b1;
    @(negedge clk);
    outsider_read_now = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%0b exp=0", in_ready); else passed++;
    total++; if (finish !== 1'b0) $display("FAIL rst_finish got=%0b exp=0", finish); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", busy); else passed++;
    total++; if (result_re !== '0) $display("FAIL rst_re got=%0d exp=0", result_re); else passed++;
    total++; if (result_im !== '0) $display("FAIL rst_im got=%0d exp=0", result_im); else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL rst_idle_busy got=%0b exp=0", busy); else passed++;
  endtask

  task automatic test_basic();
    int k; bit to;
    set_uniform(1, 0, 1, 0);
    do_start(1, 0);
    total++; if (in_ready !== 1'b1) $display("FAIL basic_ready got=%0b exp=1", in_ready); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL basic_busy got=%0b exp=1", busy); else passed++;
    feed(1);
    total++; if (in_ready !== 1'b0) $display("FAIL basic_ready_drop got=%0b exp=0", in_ready); else passed++;
    wait_finish(k, to);
    total++; if (to) $display("FAIL basic_timeout got=%0d exp=3", k); else passed++;
    total++; if (k !== 3) $display("FAIL basic_latency got=%0d exp=3", k); else passed++;
    total++; if (longint'(result_re) !== 64'sd8) $display("FAIL basic_re got=%0d exp=8", result_re); else passed++;
    total++; if (longint'(result_im) !== 64'sd0) $display("FAIL basic_im got=%0d exp=0", result_im); else passed++;
    ack();
    total++; if (finish !== 1'b0) $display("FAIL basic_finish_drop got=%0b exp=0", finish); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic_idle got=%0b exp=0", busy); else passed++;
    total++; if (longint'(result_re) !== 64'sd8) $display("FAIL basic_retain got=%0d exp=8", result_re); else passed++;
  endtask

  task automatic test_conj();
    int k; bit to;
    longint exp_re;
    set_uniform(0, 1, 0, 1);
    for (int c = 0; c < 2; c++) begin
      exp_re = (c == 0) ? -64'sd8 : 64'sd8;
      do_start(1, c[0]);
      feed(1);
      wait_finish(k, to);
      total++; if (to) $display("FAIL conj%0d_timeout got=%0d exp=3", c, k); else passed++;
      total++; if (longint'(result_re) !== exp_re) $display("FAIL conj%0d_re got=%0d exp=%0d", c, result_re, exp_re); else passed++;
      total++; if (longint'(result_im) !== 64'sd0) $display("FAIL conj%0d_im got=%0d exp=0", c, result_im); else passed++;
      ack();
    end
  endtask

  task automatic test_gaps();
    int k; bit to;
    bit pat [8] = '{1, 0, 1, 1, 0, 1, 1, 1};
    bit exp_rdy;
    set_ramp();
    do_start(4, 0);
    for (int i = 0; i < 8; i++) begin
      exp_rdy = (i <= 5);
      total++; if (in_ready !== exp_rdy) $display("FAIL gaps_ready%0d got=%0b exp=%0b", i, in_ready, exp_rdy); else passed++;
      in_valid = pat[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_finish(k, to);
    total++; if (to) $display("FAIL gaps_timeout got=%0d exp=finish", k); else passed++;
    total++; if (longint'(result_re) !== 64'sd816) $display("FAIL gaps_re got=%0d exp=816", result_re); else passed++;
    total++; if (longint'(result_im) !== 64'sd0) $display("FAIL gaps_im got=%0d exp=0", result_im); else passed++;
    ack();
  endtask

  task automatic test_extremes();
    int k; bit to;
    set_uniform(-32768, -32768, -32768, -32768);
    do_start(255, 0);
    feed(255);
    wait_finish(k, to);
    total++; if (to) $display("FAIL ext_timeout got=%0d exp=3", k); else passed++;
    total++; if (k !== 3) $display("FAIL ext_latency got=%0d exp=3", k); else passed++;
    total++; if (longint'(result_re) !== 64'sd0) $display("FAIL ext_re got=%0d exp=0", result_re); else passed++;
    total++; if (longint'(result_im) !== 64'sd4380866641920) $display("FAIL ext_im got=%0d exp=4380866641920", result_im); else passed++;
    ack();
  endtask

  task automatic test_reset_mid();
    int k; bit to;
    set_uniform(1, 0, 1, 0);
    do_start(4, 0);
    feed(2);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%0b exp=0", busy); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL rmid_ready got=%0b exp=0", in_ready); else passed++;
    total++; if (finish !== 1'b0) $display("FAIL rmid_finish got=%0b exp=0", finish); else passed++;
    total++; if (result_re !== '0) $display("FAIL rmid_re got=%0d exp=0", result_re); else passed++;
    total++; if (result_im !== '0) $display("FAIL rmid_im got=%0d exp=0", result_im); else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL rmid_idle got=%0b exp=0", busy); else passed++;
    do_start(1, 0);
    feed(1);
    wait_finish(k, to);
    total++; if (k !== 3) $display("FAIL rmid_rerun_latency got=%0d exp=3", k); else passed++;
    total++; if (longint'(result_re) !== 64'sd8) $display("FAIL rmid_rerun_re got=%0d exp=8", result_re); else passed++;
    ack();
  endtask

  task automatic test_corners();
    int k; bit to;
    set_uniform(1, 0, 1, 0);
    do_start(0, 0);
    total++; if (finish !== 1'b1) $display("FAIL zero_finish got=%0b exp=1", finish); else passed++;
    total++; if (result_re !== '0) $display("FAIL zero_re got=%0d exp=0", result_re); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL zero_ready got=%0b exp=0", in_ready); else passed++;
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 0); num_chunks = 8'd1;
      @(negedge clk);
      total++; if (finish !== 1'b1) $display("FAIL hold_finish%0d got=%0b exp=1", i, finish); else passed++;
    end
    start = 1'b1; num_chunks = 8'd1; outsider_read_now = 1'b1;
    @(negedge clk);
    start = 1'b0; outsider_read_now = 1'b0;
    total++; if (finish !== 1'b0) $display("FAIL ack_finish got=%0b exp=0", finish); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ack_start_busy got=%0b exp=0", busy); else passed++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL ack_start_idle got=%0b exp=0", busy); else passed++;
    do_start(1, 0);
    start = 1'b1; num_chunks = 8'd5; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) $display("FAIL run_start_ready got=%0b exp=0", in_ready); else passed++;
    wait_finish(k, to);
    total++; if (k !== 3) $display("FAIL run_start_latency got=%0d exp=3", k); else passed++;
    total++; if (longint'(result_re) !== 64'sd8) $display("FAIL run_start_re got=%0d exp=8", result_re); else passed++;
    ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conj();
    test_gaps();
    test_extremes();
    test_reset_mid();
    test_corners();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/complex_dot_product_stream.md
Name: complex_dot_product_stream

Overview:
- Parametrised, multi-beat successor of the eight-lane complex dot-product unit.
- Accepts a vector of complex operands as a stream of LANES-wide beats and accumulates the complex dot product across beats.
- Optional conjugate mode computes sum(a*conj(b)).
- Fixed-point signed arithmetic; holds the result until the consumer acknowledges it. Sits between the row-fetch logic and the result writeback.

Parameters:
- LANES, 8, complex elements per beat (power of two, >=2).
- DW, 16, bits per real/imag component (signed two's complement).
- CNT_W, 8, width of num_chunks (max beats per vector = 2^CNT_W-1).
- localparam LOG2L = clog2(LANES).
- localparam ACC_W = 2*DW+1+LOG2L+CNT_W (default 44). Full precision; overflow is impossible.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin a vector; sampled in IDLE only.
- num_chunks  in  CNT_W  beats in the vector; sampled with start.
- conj_b  in  1  1 = conjugate b; sampled with start.
- first_row_input  in  LANES*2*DW  operand a beat.
- second_row_input  in  LANES*2*DW  operand b beat.
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid&in_ready at clk edge.
- result_re  out  ACC_W  signed real accumulation.
- result_im  out  ACC_W  signed imag accumulation.
- finish  out  1  result valid; held until acknowledged.
- outsider_read_now  in  1  consumer acknowledge.
- busy  out  1  not IDLE.

Behaviour:
- Packing: lane 0 occupies the MS 2*DW bits. Within each lane, real is in the upper DW bits and imag in the lower DW bits.
- Per-lane arithmetic (full width, no rounding):
  - conj_b=0: re = ar*br - ai*bi, im = ar*bi + ai*br.
  - conj_b=1: re = ar*br + ai*bi, im = ai*br - ar*bi.
  - Each term is sign-extended to 2*DW+1 bits.
- Pipeline (beat accepted at edge E):
  - Four products per lane registered at E.
  - Lane combine plus adder tree registered at E+1.
  - Accumulator updated at E+2.
  - Bubbles propagate a valid bit; gaps in in_valid are legal.
- FSM states:
  - IDLE: in_ready=0. On start: clear accumulator and beat counter, latch num_chunks and conj_b, then go to RUN. If num_chunks==0, go to DONE with zero result on the next edge.
  - RUN: in_ready=1. Count accepted beats. On acceptance of beat num_chunks, go to DRAIN; in_ready drops in the cycle after the last acceptance.
  - DRAIN: in_ready=0. Wait until the pipeline valid bits are all clear and the last accumulate is done. finish=1 rises at edge E+3 of the last beat, then go to DONE.
  - DONE: finish=1; result_re/result_im stable. On outsider_read_now, go to IDLE at the next edge; finish=0 and the results are retained.
- start is ignored outside IDLE, including start coincident with outsider_read_now in DONE.
- in_valid while not in_ready is ignored; no data is consumed.
- Reset, asynchronous at any time including mid-vector:
  - State goes to IDLE.
  - in_ready=0, finish=0, busy=0, result_re=0, result_im=0.
  - Accumulator, counter and pipeline valid bits are cleared.
- busy=1 in RUN, DRAIN and DONE.

Decomposition:
- Shared package holds:
  - Lane field extract functions (re/im slice of lane k).
  - FSM state encoding (IDLE, RUN, DRAIN, DONE).
  - ACC_W derivation function.
- One natural sub-module: complex_lane_mac. It contains the per-lane product registers and combine logic, has a conj input, and outputs 2*DW+1 re/im. It is instantiated LANES times via generate. The adder tree, accumulator and FSM live in the top.

Test Plan:
- 1. Basic multiply (conj=0, num_chunks=1): all lanes a=(1,0), b=(1,0) -> finish after 3 cycles; re=8, im=0.
- 2. Conjugate mode: all lanes a=(0,1), b=(0,1):
  - conj=0 -> re=-8, im=0.
  - conj=1 -> re=8, im=0.
- 3. Multi-beat with gaps (num_chunks=4): lane k a=b=(k+1,0); in_valid toggles 1,0,1,1,0,1 -> exactly 4 beats accepted; re=816, im=0; in_ready=0 after the 4th acceptance.
- 4. Extremes (num_chunks=255, conj=0): all lanes a=b=(-32768,-32768) -> re=0, im=255*2^34=4380866641920; no wrap.
- 5. Reset mid-run: reset pulse after 2 of 4 beats -> all outputs 0, IDLE. A fresh run of test 1 then gives re=8.
- 6. Control corners:
  - num_chunks=0 -> finish one cycle after start, results 0.
  - start pulses in RUN or DONE are ignored.
  - finish held 10 cycles until outsider_read_now, then drops on the next edge.
